// File: rtl/rd_ptr_sync_ctrl.sv
// Read-side pointer control for the async FIFO: synchronizes the write
// Gray pointer, owns the read pointer, and derives empty/level/underflow.
module rd_ptr_sync_ctrl #(
   parameter int AW          = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          resetb,
   input  logic [AW:0]   wgray_async,
   input  logic          rd_req,
   output logic          rd_en,
   output logic [AW-1:0] raddr,
   output logic [AW:0]   rgray,
   output logic          empty,
   output logic [AW:0]   level,
   output logic          underflow
);

   logic [SYNC_STAGES-1:0][AW:0] wsync;
   logic [AW:0] wgray_s;
   logic [AW:0] wbin_s;
   logic [AW:0] rbin;
   logic [AW:0] rbin_next;
   logic [AW:0] rgray_next;

   function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
      logic [AW:0] b;
      b[AW] = g[AW];
      for (int i = AW - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Plain flop chain: no logic between stages keeps the Gray code
   // single-bit-change property intact across the crossing.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         wsync <= '0;
      end else begin
         wsync <= {wsync[SYNC_STAGES-2:0], wgray_async};
      end
   end

   assign wgray_s    = wsync[SYNC_STAGES-1];
   assign wbin_s     = gray2bin(wgray_s);
   assign rd_en      = rd_req & ~empty;
   assign rbin_next  = rbin + {{AW{1'b0}}, rd_en};
   assign rgray_next = rbin_next ^ (rbin_next >> 1);
   assign raddr      = rbin[AW-1:0];

   // Flags are computed from the post-pop pointer so the last pop
   // raises empty on the same edge.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         rbin      <= '0;
         rgray     <= '0;
         empty     <= 1'b1;
         level     <= '0;
         underflow <= 1'b0;
      end else begin
         rbin      <= rbin_next;
         rgray     <= rgray_next;
         empty     <= (rgray_next == wgray_s);
         level     <= wbin_s - rbin_next;
         underflow <= rd_req & empty;
      end
   end

endmodule
